// File: rtl/remainder_histogram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : remainder_histogram_pkg
// Brief    : Shared FSM encoding and width constants for the remainder histogram.
// Revision : 1.0 - initial release
// ============================================================================
package remainder_histogram_pkg;

    localparam int DEF_BIN_W = 8;
    localparam int DEF_CNT_W = 16;
    localparam int CNT_W_MAX = 32;

    // Widest supported all-ones count; instances slice it down to CNT_W.
    localparam logic [CNT_W_MAX-1:0] CNT_MAX = {CNT_W_MAX{1'b1}};

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DUMP  = 2'd3
    } hist_state_t;

endpackage
`default_nettype wire

// File: rtl/remainder_histogram_if.sv
`default_nettype none
// ============================================================================
// Module   : remainder_histogram_if
// Brief    : Sample input, control pulses and readout stream of the histogram.
//            ovf_count exists only when HIST_OVF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface remainder_histogram_if
    import remainder_histogram_pkg::*;
#(
    parameter int BIN_W = DEF_BIN_W,
    parameter int CNT_W = DEF_CNT_W
) ();

    logic              s_valid;
    logic [31:0]       s_data;
    logic              clear;
    logic              dump;
    logic              busy;
    logic              m_valid;
    logic              m_ready;
    logic [BIN_W-1:0]  m_bin;
    logic [CNT_W-1:0]  m_count;
    logic              m_last;
`ifdef HIST_OVF_CNT_EN
    logic [CNT_W-1:0]  ovf_count;
`endif

    // Histogram side: sources the readout stream.
    modport master (
        input  s_valid, s_data, clear, dump, m_ready,
`ifdef HIST_OVF_CNT_EN
        output ovf_count,
`endif
        output busy, m_valid, m_bin, m_count, m_last
    );

    // Producer / consumer side.
    modport slave (
        output s_valid, s_data, clear, dump, m_ready,
`ifdef HIST_OVF_CNT_EN
        input  ovf_count,
`endif
        input  busy, m_valid, m_bin, m_count, m_last
    );

endinterface
`default_nettype wire

// File: rtl/remainder_histogram_hist_ram.sv
`default_nettype none
// ============================================================================
// Module   : remainder_histogram_hist_ram
// Brief    : Simple dual-port RAM, 1-cycle registered read, write-first on
//            same-address collision.
// Revision : 1.0 - initial release
// ============================================================================
module remainder_histogram_hist_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Write-first keeps a read issued during the S2 write of the same bin
    // from returning the pre-increment count.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_we && (i_waddr == i_raddr)) begin
            r_rdata <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/remainder_histogram.sv
`default_nettype none
// ============================================================================
// Module   : remainder_histogram
// Brief    : Per-bin occurrence histogram of modulus remainders with streamed
//            readout. Define HIST_OVF_CNT_EN to count out-of-range samples.
// Revision : 1.0 - initial release
// ============================================================================
module remainder_histogram
    import remainder_histogram_pkg::*;
#(
    parameter int BIN_W = DEF_BIN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    remainder_histogram_if.master hist
);

    localparam logic [BIN_W-1:0] c_last_bin = {BIN_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_MAX[CNT_W-1:0];

    hist_state_t       r_state;
    hist_state_t       w_state_nxt;
    logic              w_busy;

    logic [BIN_W-1:0]  r_addr;
    logic              r_pend;
    logic              r_s1_valid;
    logic [BIN_W-1:0]  r_s1_bin;
    logic              r_s2_valid;
    logic [BIN_W-1:0]  r_s2_bin;
    logic [CNT_W-1:0]  r_s2_cnt;

    logic              r_m_valid;
    logic [BIN_W-1:0]  r_m_bin;
    logic [CNT_W-1:0]  r_m_count;
    logic              r_m_last;

    logic              w_in_range;
    logic              w_accept;
    logic              w_handshake;
    logic              w_load;
    logic              w_adv;
    logic [CNT_W-1:0]  w_rdata;
    logic [CNT_W-1:0]  w_old_cnt;
    logic [CNT_W-1:0]  w_inc_cnt;
    logic              w_we;
    logic [BIN_W-1:0]  w_waddr;
    logic [CNT_W-1:0]  w_wdata;
    logic [BIN_W-1:0]  w_raddr;

    assign w_in_range  = (hist.s_data >> BIN_W) == 32'd0;
    assign w_accept    = (r_state == ST_RUN) && hist.s_valid;
    assign w_handshake = r_m_valid && hist.m_ready;
    assign w_load      = (r_state == ST_DUMP) && r_pend && (!r_m_valid || hist.m_ready);
    assign w_adv       = w_load && (r_addr != c_last_bin);

    // S2 result overrides the stale RAM word for back-to-back hits on one bin.
    assign w_old_cnt = (r_s2_valid && (r_s2_bin == r_s1_bin)) ? r_s2_cnt : w_rdata;
    assign w_inc_cnt = (w_old_cnt == c_cnt_max) ? w_old_cnt : w_old_cnt + 1'b1;

    always_comb begin
        w_we    = r_s2_valid;
        w_waddr = r_s2_bin;
        w_wdata = r_s2_cnt;
        if (r_state == ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_addr;
            w_wdata = '0;
        end
    end

    // During readout, present the next bin as soon as the current one loads,
    // so the stream runs at one beat per cycle without a skid buffer.
    always_comb begin
        w_raddr = hist.s_data[BIN_W-1:0];
        if (r_state == ST_DUMP) begin
            w_raddr = w_adv ? r_addr + 1'b1 : r_addr;
        end
    end

    remainder_histogram_hist_ram #(
        .ADDR_W (BIN_W),
        .DATA_W (CNT_W)
    ) u_hist_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        case (r_state)
            ST_CLEAR: begin
                if (r_addr == c_last_bin) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_busy = 1'b0;
                if (hist.clear)     w_state_nxt = ST_CLEAR;
                else if (hist.dump) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // An S2 write lands at this edge; the RAM is current for DUMP.
                if (!r_s1_valid) w_state_nxt = ST_DUMP;
            end
            ST_DUMP: begin
                if (w_handshake && r_m_last) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_addr     <= '0;
            r_pend     <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_bin   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_bin   <= '0;
            r_s2_cnt   <= '0;
            r_m_valid  <= 1'b0;
            r_m_bin    <= '0;
            r_m_count  <= '0;
            r_m_last   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_s1_valid <= w_accept && w_in_range;
            r_s1_bin   <= hist.s_data[BIN_W-1:0];
            r_s2_valid <= r_s1_valid && (r_state != ST_CLEAR);
            r_s2_bin   <= r_s1_bin;
            r_s2_cnt   <= w_inc_cnt;

            case (r_state)
                ST_CLEAR: r_addr <= r_addr + 1'b1;
                ST_DUMP:  if (w_adv) r_addr <= r_addr + 1'b1;
                default:  r_addr <= '0;
            endcase

            if (r_state != ST_DUMP) begin
                r_pend <= 1'b0;
            end else if (w_load) begin
                r_pend <= w_adv;
            end else if (!(r_m_valid && r_m_last)) begin
                r_pend <= 1'b1;
            end

            if (w_load) begin
                r_m_valid <= 1'b1;
                r_m_bin   <= r_addr;
                r_m_count <= w_rdata;
                r_m_last  <= (r_addr == c_last_bin);
            end else if (w_handshake) begin
                r_m_valid <= 1'b0;
            end
        end
    end

`ifdef HIST_OVF_CNT_EN
    logic [CNT_W-1:0] r_ovf_count;

    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_CLEAR)) begin
            r_ovf_count <= '0;
        end else if (w_accept && !w_in_range && (r_ovf_count != c_cnt_max)) begin
            r_ovf_count <= r_ovf_count + 1'b1;
        end
    end

    assign hist.ovf_count = r_ovf_count;
`endif

    assign hist.busy    = w_busy;
    assign hist.m_valid = r_m_valid;
    assign hist.m_bin   = r_m_bin;
    assign hist.m_count = r_m_count;
    assign hist.m_last  = r_m_last;

endmodule
`default_nettype wire
